// File: rtl/wb_shared_intercon.sv
// rtl/wb_shared_intercon.sv - multi-master, multi-slave Wishbone interconnect
// Round-robin arbitration, address decode, unmapped-address error and stb watchdog.
module wb_shared_intercon #(
    parameter int                      NUM_MASTERS = 2,
    parameter int                      NUM_SLAVES  = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_ADDR = {NUM_SLAVES{32'hFFFF_FFFF}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'h0}},
    parameter int                      TIMEOUT     = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [32*NUM_MASTERS-1:0]   wbm_adr_i,
    input  logic [32*NUM_MASTERS-1:0]   wbm_dat_i,
    output logic [32*NUM_MASTERS-1:0]   wbm_dat_o,
    input  logic [4*NUM_MASTERS-1:0]    wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [32*NUM_SLAVES-1:0]    wbs_adr_o,
    output logic [32*NUM_SLAVES-1:0]    wbs_dat_o,
    input  logic [32*NUM_SLAVES-1:0]    wbs_dat_i,
    output logic [4*NUM_SLAVES-1:0]     wbs_sel_o,
    output logic [NUM_SLAVES-1:0]       wbs_we_o,
    output logic [NUM_SLAVES-1:0]       wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]       wbs_stb_o,
    input  logic [NUM_SLAVES-1:0]       wbs_ack_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);
    localparam int          MW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int          SW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          gidx_q, gidx_d;
    logic [MW-1:0]          ptr_q, ptr_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [31:0]            m_adr, m_dat, s_dat;
    logic [3:0]             m_sel;
    logic                   m_we, m_cyc, m_stb;
    logic                   hit, s_ack, route, ack_routed;
    logic [SW-1:0]          sidx;

    // gidx_q stays 0 out of reset, so the slave-side buses idle on master 0
    always_comb begin
        m_adr = wbm_adr_i[32*gidx_q +: 32];
        m_dat = wbm_dat_i[32*gidx_q +: 32];
        m_sel = wbm_sel_i[4*gidx_q +: 4];
        m_we  = wbm_we_i[gidx_q];
        m_cyc = wbm_cyc_i[gidx_q];
        m_stb = wbm_stb_i[gidx_q];
    end

    // Descending scan so the lowest matching slot is the last one written
    always_comb begin
        hit  = 1'b0;
        sidx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((m_adr & SLAVE_MASK[32*k +: 32]) == SLAVE_ADDR[32*k +: 32]) begin
                hit  = 1'b1;
                sidx = SW'(k);
            end
        end
    end

    assign s_ack      = wbs_ack_i[sidx];
    assign s_dat      = wbs_dat_i[32*sidx +: 32];
    assign route      = (state_q == ST_BUSY) && hit && m_cyc;
    assign ack_routed = route && m_stb && s_ack;
    assign grant_o    = grant_q;

    always_comb begin
        wbs_adr_o = {NUM_SLAVES{m_adr}};
        wbs_dat_o = {NUM_SLAVES{m_dat}};
        wbs_sel_o = {NUM_SLAVES{m_sel}};
        wbs_we_o  = {NUM_SLAVES{m_we}};
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        wbm_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        if (route) begin
            wbs_cyc_o[sidx] = 1'b1;
            wbs_stb_o[sidx] = m_stb;
        end
        if (|grant_q && hit) begin
            wbm_dat_o[32*gidx_q +: 32] = s_dat;
        end
        if (ack_routed) begin
            wbm_ack_o[gidx_q] = 1'b1;
        end
        if (state_q == ST_ERR) begin
            wbm_err_o[gidx_q] = 1'b1;
        end
    end

    int                     pick;
    int                     j;
    logic [NUM_MASTERS-1:0] cyc_sh;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pick    = 0;
        j       = 0;
        cyc_sh  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|wbm_cyc_i) begin
                    // Scan offsets high-to-low so the nearest requester above ptr wins
                    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                        j = int'(ptr_q) + i;
                        if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
                        cyc_sh = wbm_cyc_i >> j;
                        if (cyc_sh[0]) pick = j;
                    end
                    grant_d = NUM_MASTERS'(1) << pick;
                    gidx_d  = MW'(pick);
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!m_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = (gidx_q == MW'(NUM_MASTERS - 1)) ? '0 : gidx_q + MW'(1);
                end else if (m_stb && !hit) begin
                    state_d = ST_ERR;
                    cnt_d   = '0;
                end else if (m_stb && !ack_routed) begin
                    if (cnt_q + 16'd1 == TO_VAL) begin
                        state_d = ST_ERR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_ERR: begin
                state_d = ST_BUSY;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_intercon.sv
// tb/tb_wb_shared_intercon.sv - scoreboard bench for wb_shared_intercon
// Slave k acks once its stb has been high for adr[5:2] cycles.
module tb_wb_shared_intercon;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic [7:0]    wbm_sel_i;
    logic [1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_ack_o, wbm_err_o, grant_o;
    logic [127:0]  wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [15:0]   wbs_sel_o;
    logic [3:0]    wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i;

    logic [31:0]   m_adr [2];
    logic [31:0]   m_dat [2];
    logic [3:0]    m_sel [2];
    logic [1:0]    m_we, m_cyc, m_stb;

    assign wbm_adr_i = {m_adr[1], m_adr[0]};
    assign wbm_dat_i = {m_dat[1], m_dat[0]};
    assign wbm_sel_i = {m_sel[1], m_sel[0]};
    assign wbm_we_i  = m_we;
    assign wbm_cyc_i = m_cyc;
    assign wbm_stb_i = m_stb;

    wb_shared_intercon #(
        .NUM_MASTERS(2),
        .NUM_SLAVES (4),
        .SLAVE_ADDR ({32'h0000_3000, 32'hFFFF_FFFF, 32'h0000_2000, 32'h0000_1000}),
        .SLAVE_MASK ({32'hFFFF_F000, 32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i),
        .wbm_stb_i(wbm_stb_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i),
        .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o), .wbs_ack_i(wbs_ack_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sdata(input int k, input logic [31:0] adr);
        if (adr == 32'h0000_1004) return 32'hDEAD_BEEF;
        return {4'(k), adr[27:0]} ^ 32'hA5A5_0000;
    endfunction

    logic [3:0] scnt [4];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wbs_stb_o[k] && !wbs_ack_i[k]) scnt[k] <= scnt[k] + 4'd1;
            else scnt[k] <= 4'd0;
        end
    end
    always_comb begin
        wbs_ack_i = '0;
        wbs_dat_i = '0;
        for (int k = 0; k < 4; k++) begin
            wbs_ack_i[k] = wbs_stb_o[k] && (scnt[k] == wbs_adr_o[32*k+2 +: 4]);
            wbs_dat_i[32*k +: 32] = sdata(k, wbs_adr_o[32*k +: 32]);
        end
    end

    // Memory map as seen by software: three 4 KiB windows, everything else unmapped
    function automatic int model_slave(input logic [31:0] adr);
        case (adr[31:12])
            20'h00001: return 0;
            20'h00002: return 1;
            20'h00003: return 3;
            default:   return -1;
        endcase
    endfunction

    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t       eq0[$];
    exp_t       eq1[$];
    logic [1:0] grant_log[$];
    int         gap_log[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic monitor();
        logic [1:0] prev_grant = 2'b00;
        logic [1:0] prev_cyc   = 2'b00;
        logic [1:0] prev_err   = 2'b00;
        logic       prev_rst   = 1'b1;
        int         zrun       = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (wbm_ack_o[m] || wbm_err_o[m]) begin
                    if ((m == 0 && eq0.size() == 0) || (m == 1 && eq1.size() == 0)) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp m%0d: got ack=%b err=%b expected none", m, wbm_ack_o[m], wbm_err_o[m]);
                    end else begin
                        e = (m == 0) ? eq0.pop_front() : eq1.pop_front();
                        check($sformatf("resp_kind_m%0d", m), {29'd0, grant_o[m], wbm_ack_o[m], wbm_err_o[m]},
                              {29'd0, 1'b1, !e.is_err, e.is_err});
                        if (!e.is_err && e.chk_dat && wbm_ack_o[m])
                            check($sformatf("rdata_m%0d", m), wbm_dat_o[32*m +: 32], e.dat);
                    end
                end
                if (wbm_err_o[m] && prev_err[m])
                    check($sformatf("err_width_m%0d", m), 32'd2, 32'd1);
            end
            if (wbs_cyc_o != 4'b0) begin
                check("slave_cyc_onehot", 32'($countones(wbs_cyc_o)), 32'd1);
                check("slave2_idle", 32'(wbs_cyc_o[2]), 32'd0);
                check("stb_within_cyc", 32'(wbs_stb_o & ~wbs_cyc_o), 32'd0);
            end
            if (grant_o != prev_grant) begin
                if (prev_grant != 2'b00 && grant_o != 2'b00)
                    check("grant_swap", 32'(grant_o), 32'd0);
                if (prev_grant != 2'b00 && grant_o == 2'b00 && !prev_rst)
                    check("grant_lock", 32'(prev_cyc & prev_grant), 32'd0);
                if (prev_grant == 2'b00 && grant_o != 2'b00) begin
                    grant_log.push_back(grant_o);
                    gap_log.push_back(zrun);
                end
            end
            zrun       = (grant_o == 2'b00) ? zrun + 1 : 0;
            prev_grant = grant_o;
            prev_cyc   = wbm_cyc_i;
            prev_err   = wbm_err_o;
            prev_rst   = rst;
        end
    endtask

    task automatic push_exp(input int m, input exp_t e);
        if (m == 0) eq0.push_back(e);
        else eq1.push_back(e);
    endtask

    task automatic cyc_up(input int m);
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b1;
    endtask

    // Issue one beat (caller is at posedge+1 with cyc high); n = granted cycles until response
    task automatic beat(input int m, input logic [31:0] adr, input logic we, output int n);
        exp_t e;
        int   s;
        int   waited;
        bit   done;
        s         = model_slave(adr);
        e.is_err  = (s < 0) || (int'(adr[5:2]) >= TO);
        e.chk_dat = !we;
        e.dat     = (s < 0) ? 32'd0 : sdata(s, adr);
        push_exp(m, e);
        m_adr[m] = adr;
        m_we[m]  = we;
        m_dat[m] = $urandom;
        m_sel[m] = 4'(1 + $urandom_range(0, 14));
        m_stb[m] = 1'b1;
        n = 0;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            waited++;
            if (grant_o[m]) n++;
            if (wbm_ack_o[m] || wbm_err_o[m]) begin
                done = 1'b1;
            end else if (waited >= 300) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_timeout m%0d: got no response after %0d cycles expected ack or err", m, waited);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_stb[m] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        case ($urandom_range(0, 5))
            0, 5:    base = 32'h0000_1000;
            1:       base = 32'h0000_2000;
            2:       base = 32'h0000_3000;
            3:       base = 32'h0000_5000;
            default: base = 32'h8000_0000;
        endcase
        return base | (32'($urandom_range(0, 63)) << 6) | (32'($urandom_range(0, 9)) << 2);
    endfunction

    task automatic rand_master(input int m, input int ntx);
        int n;
        int nb;
        for (int t = 0; t < ntx; t++) begin
            cyc_up(m);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                beat(m, rand_addr(), 1'($urandom_range(0, 1)), n);
                if (b < nb - 1) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            m_cyc[m] = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic alt_master(input int m);
        int n;
        for (int t = 0; t < 3; t++) begin
            cyc_up(m);
            beat(m, 32'h0000_2000 | (32'($urandom_range(0, 7)) << 2), 1'b0, n);
            m_cyc[m] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, n0, n1;
        rst = 1'b1;
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0;
            m_dat[m] = '0;
            m_sel[m] = '0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_wbs_cyc", 32'(wbs_cyc_o), 32'd0);
        check("rst_wbs_stb", 32'(wbs_stb_o), 32'd0);
        check("rst_ack_err", 32'({wbm_ack_o, wbm_err_o}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both masters request together after reset, then keep requesting
        grant_log.delete();
        gap_log.delete();
        fork
            alt_master(0);
            alt_master(1);
        join
        check("alt_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) begin
            check($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check($sformatf("alt_gap_%0d", i), 32'(gap_log[i]), 32'd1);
        end
        repeat (2) @(posedge clk);

        // Directed read of 0x1004 from master 0
        @(posedge clk);
        #1;
        push_exp(0, '{is_err: 1'b0, chk_dat: 1'b1, dat: 32'hDEAD_BEEF});
        m_adr[0] = 32'h0000_1004;
        m_we[0]  = 1'b0;
        m_sel[0] = 4'hF;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        @(negedge clk);
        check("rd_grant_pre", 32'(grant_o), 32'd0);
        @(negedge clk);
        check("rd_grant", 32'(grant_o), 32'd1);
        check("rd_stb_s0", 32'(wbs_stb_o), 32'd1);
        check("rd_ack_early", 32'(wbm_ack_o), 32'd0);
        @(negedge clk);
        check("rd_ack", 32'(wbm_ack_o), 32'd1);
        check("rd_cyc_s0", 32'(wbs_cyc_o), 32'd1);
        check("rd_dat_m1_zero", wbm_dat_o[63:32], 32'd0);
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        repeat (2) @(posedge clk);

        // Unmapped access from master 1
        @(posedge clk);
        #1;
        push_exp(1, '{is_err: 1'b1, chk_dat: 1'b0, dat: 32'd0});
        m_adr[1] = 32'h8000_0000;
        m_we[1]  = 1'b0;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        @(negedge clk);
        check("um_grant_pre", 32'(grant_o), 32'd0);
        @(negedge clk);
        check("um_grant", 32'(grant_o), 32'd2);
        check("um_err_early", 32'(wbm_err_o), 32'd0);
        check("um_no_stb", 32'(wbs_stb_o), 32'd0);
        @(negedge clk);
        check("um_err", 32'(wbm_err_o), 32'd2);
        check("um_no_ack", 32'(wbm_ack_o), 32'd0);
        check("um_no_stb2", 32'(wbs_stb_o), 32'd0);
        @(posedge clk);
        #1;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        @(negedge clk);
        check("um_err_done", 32'(wbm_err_o), 32'd0);
        repeat (2) @(posedge clk);

        // Watchdog boundary: ack on the 8th stb cycle wins, no ack means err after 8
        cyc_up(0);
        beat(0, 32'h0000_101C, 1'b0, n);
        check("to_ack_cycles", 32'(n), 32'd8);
        m_cyc[0] = 1'b0;
        cyc_up(0);
        beat(0, 32'h0000_1020, 1'b0, n);
        check("to_err_cycles_l8", 32'(n), 32'd9);
        m_cyc[0] = 1'b0;
        cyc_up(0);
        beat(0, 32'h0000_5000, 1'b0, n);
        check("slave2_err_cycles", 32'(n), 32'd2);
        m_cyc[0] = 1'b0;

        // Reset with a stb pending on master 0 (pointer currently at 1)
        cyc_up(0);
        m_adr[0] = 32'h0000_103C;
        m_stb[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_busy", 32'(wbs_stb_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_cyc", 32'(wbs_cyc_o), 32'd0);
        check("rst_mid_grant", 32'(grant_o), 32'd0);
        check("rst_mid_ack_err", 32'({wbm_ack_o, wbm_err_o}), 32'd0);
        grant_log.delete();
        fork
            begin cyc_up(0); beat(0, 32'h0000_2008, 1'b0, n0); m_cyc[0] = 1'b0; end
            begin cyc_up(1); beat(1, 32'h0000_3004, 1'b0, n1); m_cyc[1] = 1'b0; end
        join
        check("post_rst_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'd0, 32'd1);

        // Randomized traffic from both masters
        fork
            rand_master(0, 20);
            rand_master(1, 20);
        join
        repeat (5) @(posedge clk);
        check("eq0_drained", 32'(eq0.size()), 32'd0);
        check("eq1_drained", 32'(eq1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_shared_intercon.md
Name: wb_shared_intercon

Overview:
- Parametrised multi-master, multi-slave Wishbone interconnect.
- Successor to the single-master, fixed four-slave decoder. Lets the moxie core's instruction and data ports, and later DMA/debug masters, share one slave set.
- Adds registered round-robin arbitration, an error response for unmapped addresses, and a bus-timeout watchdog.
- Sits between the masters and the bootrom/testram/peripheral slaves in the SoC top level.

Parameters:
- NUM_MASTERS, 2: number of master ports (1..4).
- NUM_SLAVES, 4: number of slave ports (1..8).
- SLAVE_ADDR, {NUM_SLAVES{32'hFFFF_FFFF}}: packed 32*NUM_SLAVES base addresses; slave k at bits [32k+31:32k].
- SLAVE_MASK, {NUM_SLAVES{32'h0}}: packed 32*NUM_SLAVES decode masks, same layout.
- TIMEOUT, 255: cycles of unacknowledged stb before an error is forced (1..65535).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- wbm_adr_i  in  32*NUM_MASTERS  master addresses.
- wbm_dat_i  in  32*NUM_MASTERS  master write data.
- wbm_dat_o  out  32*NUM_MASTERS  read data to masters.
- wbm_sel_i  in  4*NUM_MASTERS  byte selects.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_cyc_i  in  NUM_MASTERS  cycle requests.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_ack_o  out  NUM_MASTERS  acknowledges.
- wbm_err_o  out  NUM_MASTERS  error terminations.
- wbs_adr_o  out  32*NUM_SLAVES  slave addresses.
- wbs_dat_o  out  32*NUM_SLAVES  write data to slaves.
- wbs_dat_i  in  32*NUM_SLAVES  slave read data.
- wbs_sel_o  out  4*NUM_SLAVES  byte selects.
- wbs_we_o  out  NUM_SLAVES  write enables.
- wbs_cyc_o  out  NUM_SLAVES  slave cycles.
- wbs_stb_o  out  NUM_SLAVES  slave strobes.
- wbs_ack_i  in  NUM_SLAVES  slave acknowledges.
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/observability).

Behaviour:
- Reset (rst_i high at posedge):
  - grant_o=0; state IDLE; round-robin pointer=0; timeout counter=0.
  - All wbs_cyc_o/wbs_stb_o/wbm_ack_o/wbm_err_o low.
  - Data/address outputs are don't-care but driven from the master-0 mux.
  - Reset mid-transaction aborts it: slave cyc/stb drop at that edge; the master receives no ack or err.
- Decode: slave k matches when (adr & SLAVE_MASK[k]) == SLAVE_ADDR[k].
  - Lowest matching index wins.
  - mask=0 with addr=all-ones never matches, so the slot is disabled.
  - Decode is combinational on the granted master's address.
- States:
  - IDLE: if any wbm_cyc_i is high, grant the first requesting master searching from pointer upward, wrapping. Go to BUSY next edge. Grant latency is 1 cycle from cyc to grant_o.
  - BUSY: granted master's cyc/stb/we/sel/adr/dat are routed to the decoded slave only. wbs_cyc_o of the decoded slave follows master cyc; all other slaves see cyc=stb=0.
    - Slave ack is returned combinationally to wbm_ack_o of the granted master. Read data is muxed combinationally; ungranted masters see ack=err=0 and dat=0.
    - stb high with no decode match: go to ERR.
    - Timeout counter reaches TIMEOUT: go to ERR.
    - Granted master drops cyc: go to IDLE, pointer = granted index + 1 (mod NUM_MASTERS).
  - ERR: wbm_err_o of the granted master is high exactly one cycle; no slave stb; counter cleared; return to BUSY.
- Grant lock: grant is never changed while the granted master holds cyc, including across multiple stb beats and idle stb-low gaps.
- Timeout counter: 16 bits, increments each cycle stb is high and the routed ack is low. Clears on ack, on stb low, and on entering ERR.
- Simultaneous events: ack and timeout reaching TIMEOUT in the same cycle means ack wins; no error and the counter clears. cyc dropping and an unmapped stb in the same cycle means IDLE wins; no error.
- Re-arbitration after release costs 1 idle cycle (IDLE state). Back-to-back requests from two masters therefore alternate, with one dead cycle between grants.

Test Plan:
- Slave0 at 0x0000_1000, mask 0xFFFF_F000. Master0 reads 0x1004; slave acks in 2 cycles with 0xDEADBEEF -> grant_o=01 one cycle after cyc; wbs_stb_o[0]=1; wbm_dat_o[31:0]=0xDEADBEEF with ack; other slaves idle.
- Both masters raise cyc in the same cycle after reset -> master0 granted first. After master0 drops cyc, one IDLE cycle, then grant_o=10. Repeat with both persistently requesting -> grants strictly alternate 01,10,01,10.
- Master1 strobes unmapped 0x8000_0000 -> wbm_err_o[1] high for exactly 1 cycle, 1 cycle after stb; no wbs_stb_o asserted; no ack.
- TIMEOUT=8, slave never acks -> wbm_err_o pulses after 8 stb-high cycles. If the slave acks on cycle 8 instead, the response is ack with no err.
- rst_i asserted mid-BUSY with a slave stb pending -> next edge: all wbs_cyc_o=0, grant_o=0, no ack/err. The next request is arbitrated from pointer 0.
- Slave2 left at defaults, address matching nothing else -> err returned; slave2 cyc never asserted.
